add_sub_serial: RTL and testbench



---
 rtl/add_sub_serial.sv | 169 ++++++++++++++++
 tb/tb_add_sub_serial.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/add_sub_serial.sv
// ---------------------------------------------------------------------------
// add_sub_serial
//
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operation is
// processed DIGIT bits per clock through a single DIGIT-bit full-adder chain,
// least significant digit first. Subtraction is done as A + ~B + 1: the
// inverted B is latched at start and the initial carry is set to 1.
//
// Optional feature (compile-time macro ADD_SUB_SAT_EN):
//   defined     - on signed overflow SUM saturates to the largest positive
//                 (0111..1) or most negative (1000..0) value.
//   not defined - SUM wraps modulo 2^WIDTH.
//   COUT and OVF are reported identically in both builds.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset (highest priority)
//   start  in   1      operation request, only sampled while busy=0
//   A      in   WIDTH  operand A, latched at start
//   B      in   WIDTH  operand B, latched at start
//   A_S    in   1      mode, latched at start: 1 = A-B, 0 = A+B
//   busy   out  1      high while an operation is in RUN or DONE
//   done   out  1      one-cycle pulse; SUM/COUT/OVF valid from this cycle on
//   SUM    out  WIDTH  result, held until the next done or reset
//   COUT   out  1      carry out of MSB (for subtract: 1 = no borrow)
//   OVF    out  1      signed overflow
// ---------------------------------------------------------------------------
module add_sub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             A_S,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int NDIG  = WIDTH / DIGIT;
    // Counter and bit-index widths never collapse to zero bits when NDIG=1.
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;        // latched A
    logic [WIDTH-1:0] b_r;        // latched B, already inverted for subtract
    logic [WIDTH-1:0] res_r;      // digits produced so far
    logic [CNT_W-1:0] cnt_r;      // index of the digit being processed
    logic             carry_r;    // carry into the current digit

    logic [IDX_W-1:0] bit_idx_s;  // LSB position of the current digit
    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT-1:0] sum_dig_s;
    logic [DIGIT:0]   chain_s;    // chain_s[i] = carry into bit i of the digit
    logic [WIDTH-1:0] res_full_s; // complete result including the current digit
    logic [WIDTH-1:0] sum_next_s; // value loaded into SUM on the last digit
    logic             ovf_next_s;

    // One-bit full adder, returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    // Digit slice selection, ripple chain, and final result / overflow forming.
    always_comb begin
        bit_idx_s  = IDX_W'(cnt_r) * IDX_W'(DIGIT);
        a_dig_s    = a_r[bit_idx_s +: DIGIT];
        b_dig_s    = b_r[bit_idx_s +: DIGIT];
        chain_s    = '0;
        sum_dig_s  = '0;
        chain_s[0] = carry_r;
        for (int i = 0; i < DIGIT; i++) begin
            {chain_s[i+1], sum_dig_s[i]} = full_add(a_dig_s[i], b_dig_s[i], chain_s[i]);
        end
        res_full_s = res_r;
        res_full_s[bit_idx_s +: DIGIT] = sum_dig_s;
        // Only meaningful on the last digit: carry into MSB vs carry out of MSB.
        ovf_next_s = chain_s[DIGIT-1] ^ chain_s[DIGIT];
`ifdef ADD_SUB_SAT_EN
        // Overflow with a negative-looking result means the true value was
        // too large positive, and vice versa.
        if (ovf_next_s) begin
            if (res_full_s[WIDTH-1]) begin
                sum_next_s = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                sum_next_s = {1'b1, {(WIDTH-1){1'b0}}};
            end
        end else begin
            sum_next_s = res_full_s;
        end
`else
        sum_next_s = res_full_s;
`endif
    end

    // Control FSM with operand latching, digit accumulation and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            SUM     <= '0;
            COUT    <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_r     <= A;
                        b_r     <= B ^ {WIDTH{A_S}};
                        carry_r <= A_S;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_r[bit_idx_s +: DIGIT] <= sum_dig_s;
                    carry_r <= chain_s[DIGIT];
                    if (cnt_r == LAST_DIG) begin
                        // Outputs are loaded on this edge so they are valid
                        // in the DONE cycle together with the done pulse.
                        SUM     <= sum_next_s;
                        COUT    <= chain_s[DIGIT];
                        OVF     <= ovf_next_s;
                        done    <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here.
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_serial.sv
module tb_add_sub_serial;

`ifdef ADD_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        as;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2;
    logic [15:0] a1, b1, a2, b2;
    logic        as1, as2;
    logic        busy1, done1, cout1, ovf1;
    logic        busy2, done2, cout2, ovf2;
    logic [15:0] sum1, sum2;

    int total = 0;
    int bad   = 0;

    vec_t vecs[8];

    always #5 clk = ~clk;

    add_sub_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .A_S(as1),
        .busy(busy1), .done(done1), .SUM(sum1), .COUT(cout1), .OVF(ovf1)
    );

    add_sub_serial #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .A_S(as2),
        .busy(busy2), .done(done2), .SUM(sum2), .COUT(cout2), .OVF(ovf2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [15:0] a,
                         input logic [15:0] b, input logic as);
        if (sel == 0) begin
            start1 = s; a1 = a; b1 = b; as1 = as;
        end else begin
            start2 = s; a2 = a; b2 = b; as2 = as;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy1 : busy2;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel == 0) ? done1 : done2;
    endfunction
    function automatic logic [15:0] get_sum(input int sel);
        return (sel == 0) ? sum1 : sum2;
    endfunction
    function automatic logic get_cout(input int sel);
        return (sel == 0) ? cout1 : cout2;
    endfunction
    function automatic logic get_ovf(input int sel);
        return (sel == 0) ? ovf1 : ovf2;
    endfunction

    // Full operation: start in cycle 0, done expected in cycle lat, then idle.
    task automatic run_op(input int sel, input vec_t v, input string nm);
        int lat;
        logic [15:0] prev_sum;
        lat = (sel == 0) ? 5 : 2;
        @(negedge clk);
        prev_sum = get_sum(sel);
        drive(sel, 1'b1, v.a, v.b, v.as);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            // Scramble inputs after the start edge; only latched copies count.
            if (c == 1) drive(sel, 1'b0, ~v.a, ~v.b, ~v.as);
            chk({nm, " busy"}, 32'(get_busy(sel)), 32'd1);
            chk({nm, " done"}, 32'(get_done(sel)), (c == lat) ? 32'd1 : 32'd0);
            if (c < lat) chk({nm, " sum hold"}, 32'(get_sum(sel)), 32'(prev_sum));
        end
        chk({nm, " sum"},  32'(get_sum(sel)),  32'(v.sum));
        chk({nm, " cout"}, 32'(get_cout(sel)), 32'(v.cout));
        chk({nm, " ovf"},  32'(get_ovf(sel)),  32'(v.ovf));
        @(negedge clk);
        chk({nm, " idle busy"}, 32'(get_busy(sel)), 32'd0);
        chk({nm, " idle done"}, 32'(get_done(sel)), 32'd0);
        chk({nm, " sum kept"},  32'(get_sum(sel)),  32'(v.sum));
    endtask

    initial begin
        vec_t v16;
        vecs[0] = '{16'h1234, 16'h0FF1, 1'b0, 16'h2225, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'h9999, 1'b1, 1'b0};

        rst = 1'b1;
        drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        drive(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy1), 32'd0);
        chk("rst done", 32'(done1), 32'd0);
        chk("rst sum",  32'(sum1),  32'd0);
        chk("rst cout", 32'(cout1), 32'd0);
        chk("rst ovf",  32'(ovf1),  32'd0);
        chk("rst busy16", 32'(busy2), 32'd0);
        chk("rst sum16",  32'(sum2),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(0, vecs[i], $sformatf("vec%0d", i));
        end

        // start while busy (RUN and DONE) is ignored; next start in cycle 7 accepted.
        @(negedge clk);
        drive(0, 1'b1, 16'h1234, 16'h0FF1, 1'b0);                 // cycle 0
        @(negedge clk); drive(0, 1'b0, 16'h1234, 16'h0FF1, 1'b0); // cycle 1
        chk("ign busy c1", 32'(busy1), 32'd1);
        @(negedge clk); drive(0, 1'b1, 16'hAAAA, 16'h0FF1, 1'b1); // cycle 2
        @(negedge clk); drive(0, 1'b0, 16'h1234, 16'h0FF1, 1'b0); // cycle 3
        chk("ign done c3", 32'(done1), 32'd0);
        @(negedge clk);                                            // cycle 4
        chk("ign done c4", 32'(done1), 32'd0);
        @(negedge clk);                                            // cycle 5
        chk("ign done c5", 32'(done1), 32'd1);
        chk("ign sum", 32'(sum1), 32'h2225);
        chk("ign cout", 32'(cout1), 32'd0);
        drive(0, 1'b1, 16'h0005, 16'h0007, 1'b1);                 // in DONE: ignored
        @(negedge clk);                                            // cycle 6
        chk("ign busy c6", 32'(busy1), 32'd0);
        chk("ign done c6", 32'(done1), 32'd0);
        drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);                                            // cycle 7
        drive(0, 1'b1, 16'h0005, 16'h0007, 1'b1);
        for (int c = 8; c <= 12; c++) begin
            @(negedge clk);
            if (c == 8) drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            chk($sformatf("restart busy c%0d", c), 32'(busy1), 32'd1);
            chk($sformatf("restart done c%0d", c), 32'(done1), (c == 12) ? 32'd1 : 32'd0);
        end
        chk("restart sum", 32'(sum1), 32'hFFFE);
        chk("restart cout", 32'(cout1), 32'd0);

        // Reset in cycle 3 aborts the operation without a done pulse.
        @(negedge clk);
        drive(0, 1'b1, 16'h1234, 16'h0FF1, 1'b0);                 // cycle 0
        @(negedge clk); drive(0, 1'b0, 16'h1234, 16'h0FF1, 1'b0); // cycle 1
        @(negedge clk);                                            // cycle 2
        @(negedge clk); rst = 1'b1;                                // cycle 3
        @(negedge clk);                                            // cycle 4
        chk("abort busy", 32'(busy1), 32'd0);
        chk("abort done", 32'(done1), 32'd0);
        chk("abort sum",  32'(sum1),  32'd0);
        chk("abort cout", 32'(cout1), 32'd0);
        chk("abort ovf",  32'(ovf1),  32'd0);
        rst = 1'b0;
        for (int c = 5; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("abort no done c%0d", c), 32'(done1), 32'd0);
            chk($sformatf("abort no busy c%0d", c), 32'(busy1), 32'd0);
        end

        // DIGIT=WIDTH: single RUN cycle, done in cycle 2.
        v16 = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
        run_op(1, v16, "d16 add");
        v16 = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
        run_op(1, v16, "d16 ovf");
        v16 = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        run_op(1, v16, "d16 sub");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
